seq_pulse_monitor: RTL and testbench
====================================

// Module: seq_pulse_monitor
// PURPOSE
//  Downstream checker for the sequence-generator FSM: consumes its 1-bit y_out stream,
//  counts pulses, measures the cycle gap between rising edges against a programmed period,
//  and reports lock plus sticky gap/width errors. Sits beside the generator on the same clk.
// PARAMETERS
//  GAP_W   8   width of gap counter / last_gap / expected_gap (saturates at 2^GAP_W-1)
//  CNT_W   16  width of pulse_count (saturates at 2^CNT_W-1)
//  LOCK_N  4   consecutive matching gaps required to assert locked (1..15)
//  HIST_D  8   depth of sample history (used only with SEQ_MON_HIST_EN)
// PORTS
//  clk           in   1       single clock, all state on posedge
//  reset         in   1       asynchronous, active-high; clears all state
//  y_in          in   1       pulse stream (generator y_out)
//  clear         in   1       synchronous clear, same effect as reset
//  expected_gap  in   GAP_W   required cycles between consecutive rising edges
//  pulse_count   out  CNT_W   number of rising edges since reset/clear
//  last_gap      out  GAP_W   most recently captured gap
//  gap_valid     out  1       1-cycle strobe: last_gap updated at this edge
//  locked        out  1       LOCK_N consecutive gaps equal expected_gap
//  err_gap       out  1       sticky: gap mismatch while locked
//  err_width     out  1       sticky: y_in high on 2+ consecutive samples
//  hist          out  HIST_D  last HIST_D y_in samples, bit 0 newest (macro only)
// BEHAVIOUR
//  - Reset/clear: all outputs 0, y_d=0, gap_cnt=0, match_cnt=0, state IDLE.
//  - clear has priority over every same-cycle event; y_in sampled at that edge is ignored.
//  - y_d registers y_in each edge; rise = y_in & ~y_d (evaluated at the sampling edge).
//  - All outputs registered; they update at the edge that samples rise (latency 0 after sample).
//  - pulse_count += 1 on each rise, saturating.
//  - gap_cnt: loads 1 on rise; else +1 per cycle in MEASURE/LOCKED, saturating at all-ones.
//    Gap = edges between rises: rises at edges t and t+5 -> last_gap = 5.
//  - FSM:
//    IDLE:    rise -> MEASURE (first pulse; no gap captured, gap_valid stays 0).
//    MEASURE: rise -> last_gap<=gap_cnt, gap_valid=1; match -> match_cnt+1, else match_cnt<=0;
//             match_cnt reaching LOCK_N -> LOCKED, locked=1 at that edge.
//    LOCKED:  rise with match -> stay; rise with mismatch -> err_gap<=1, locked<=0,
//             match_cnt<=0, -> MEASURE (mismatching gap still captured on last_gap).
//  - match = (gap_cnt == expected_gap); expected_gap=0 never matches, never locks.
//  - Saturated gap (e.g. 255 for GAP_W=8) is captured and compared like any other value.
//  - expected_gap changes take effect at the next rise; no retroactive effect on match_cnt.
//  - err_width: set when y_in & y_d; a multi-cycle pulse counts as one rise only.
//  - err_gap/err_width clear only on reset or clear.
//  - Reset mid-operation: asynchronous clear to reset values; first rise after release -> MEASURE.
// CONFIGURATION
//  SEQ_MON_HIST_EN defined: hist is a HIST_D-bit shift register, hist <= {hist[HIST_D-2:0], y_in}
//   each edge, 0 on reset/clear. Not defined: no shift register; hist tied to 0.
// TESTING
//  1 Pulses every 5 cycles, expected_gap=5 -> gap_valid per pulse from 2nd, last_gap=5,
//    locked=1 at 5th rise, pulse_count=5.
//  2 Locked at gap 5, then one gap of 6 -> last_gap=6, err_gap=1, locked=0;
//    relocks after 4 more gaps of 5, err_gap stays 1.
//  3 y_in high 3 consecutive cycles -> err_width=1, pulse_count +1 only.
//  4 clear asserted same edge as a rise -> all outputs 0, state IDLE, rise not counted.
//  5 GAP_W=8, single pulse then 300 idle cycles then pulse -> last_gap=255, no wrap.
//  6 reset pulsed between clock edges while locked -> outputs 0 immediately; with
//    SEQ_MON_HIST_EN, hist=0 then fills newest-first.

Source files
------------

// File: rtl/seq_pulse_monitor.sv
// Pulse-stream checker: counts rising edges, measures rise-to-rise gaps against expected_gap, reports lock and sticky errors.
// Optional sample history register is enabled by defining SEQ_MON_HIST_EN.
module seq_pulse_monitor #(
    parameter int GAP_W  = 8,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4,
    parameter int HIST_D = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y_in,
    input  logic             clear,
    input  logic [GAP_W-1:0] expected_gap,
    output logic [CNT_W-1:0] pulse_count,
    output logic [GAP_W-1:0] last_gap,
    output logic             gap_valid,
    output logic             locked,
    output logic             err_gap,
    output logic             err_width,
    output logic [HIST_D-1:0] hist
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    state_t           state;
    state_t           state_nxt;
    logic             y_d;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       match_cnt;
    logic [3:0]       match_cnt_nxt;
    logic [3:0]       match_cnt_inc;
    logic             rise;
    logic             match;
    logic             capture;
    logic             err_gap_set;

    assign rise          = y_in & ~y_d;
    // A zero expected gap can never be produced by the counter, so it must never match.
    assign match         = (expected_gap != '0) && (gap_cnt == expected_gap);
    assign match_cnt_inc = match_cnt + 4'd1;

    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        capture       = 1'b0;
        err_gap_set   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                    if (match) begin
                        match_cnt_nxt = match_cnt_inc;
                        if (match_cnt_inc == LOCK_V) state_nxt = LOCKED;
                    end else begin
                        match_cnt_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (rise) begin
                    capture = 1'b1;
                    if (!match) begin
                        err_gap_set   = 1'b1;
                        match_cnt_nxt = 4'd0;
                        state_nxt     = MEASURE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            y_d         <= 1'b0;
            gap_cnt     <= '0;
            match_cnt   <= 4'd0;
            pulse_count <= '0;
            last_gap    <= '0;
            gap_valid   <= 1'b0;
            locked      <= 1'b0;
            err_gap     <= 1'b0;
            err_width   <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            y_d         <= 1'b0;
            gap_cnt     <= '0;
            match_cnt   <= 4'd0;
            pulse_count <= '0;
            last_gap    <= '0;
            gap_valid   <= 1'b0;
            locked      <= 1'b0;
            err_gap     <= 1'b0;
            err_width   <= 1'b0;
        end else begin
            state     <= state_nxt;
            y_d       <= y_in;
            match_cnt <= match_cnt_nxt;
            gap_valid <= capture;
            locked    <= (state_nxt == LOCKED);
            if (capture) last_gap <= gap_cnt;
            if (err_gap_set) err_gap <= 1'b1;
            if (y_in & y_d) err_width <= 1'b1;
            if (rise && !(&pulse_count)) pulse_count <= pulse_count + 1'b1;
            // Counting starts at 1 so the value seen at the next rise equals the edge distance.
            if (rise) begin
                gap_cnt <= {{(GAP_W-1){1'b0}}, 1'b1};
            end else if (state != IDLE && !(&gap_cnt)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_MON_HIST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (clear) begin
            hist <= '0;
        end else begin
            hist <= {hist[HIST_D-2:0], y_in};
        end
    end
`else
    assign hist = '0;
`endif

endmodule

// File: tb/tb_seq_pulse_monitor.sv
// Randomized and directed bench for seq_pulse_monitor, checked every cycle against an edge-index reference model.
module tb_seq_pulse_monitor;
    localparam int GAP_W  = 8;
    localparam int CNT_W  = 16;
    localparam int LOCK_N = 4;
    localparam int HIST_D = 8;
    localparam int GMAX   = (1 << GAP_W) - 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              y_in = 1'b0;
    logic              clear = 1'b0;
    logic [GAP_W-1:0]  expected_gap = 8'd5;
    logic [CNT_W-1:0]  pulse_count;
    logic [GAP_W-1:0]  last_gap;
    logic              gap_valid, locked, err_gap, err_width;
    logic [HIST_D-1:0] hist;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    seq_pulse_monitor #(.GAP_W(GAP_W), .CNT_W(CNT_W), .LOCK_N(LOCK_N), .HIST_D(HIST_D)) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .clear(clear), .expected_gap(expected_gap),
        .pulse_count(pulse_count), .last_gap(last_gap), .gap_valid(gap_valid),
        .locked(locked), .err_gap(err_gap), .err_width(err_width), .hist(hist)
    );

    always #5 clk = ~clk;

    // Reference model: rises are tracked by absolute edge index; gap is the index difference.
    int          m_edge = 0;
    int          m_last_rise = 0;
    bit          m_seen = 0;
    int          m_run = 0;
    int          m_cnt = 0;
    int          m_gap = 0;
    bit          m_gv = 0, m_locked = 0, m_eg = 0, m_ew = 0, m_yd = 0;
    logic [HIST_D-1:0] m_hist = '0;

    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            m_seen = 0; m_run = 0; m_cnt = 0; m_gap = 0;
            m_gv = 0; m_locked = 0; m_eg = 0; m_ew = 0; m_yd = 0; m_hist = '0;
        end else begin
            m_gv = 0;
            if (y_in && m_yd) m_ew = 1;
            if (y_in && !m_yd) begin
                if (m_cnt < CMAX) m_cnt++;
                if (m_seen) begin
                    int g;
                    g = m_edge - m_last_rise;
                    if (g > GMAX) g = GMAX;
                    m_gap = g;
                    m_gv = 1;
                    if (expected_gap != 0 && g == int'(expected_gap)) begin
                        m_run++;
                    end else begin
                        if (m_run >= LOCK_N) m_eg = 1;
                        m_run = 0;
                    end
                    m_locked = (m_run >= LOCK_N);
                end
                m_seen = 1;
                m_last_rise = m_edge;
            end
            m_yd = y_in;
`ifdef SEQ_MON_HIST_EN
            m_hist = {m_hist[HIST_D-2:0], y_in};
`endif
        end
        m_edge++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pulse_count", pulse_count, m_cnt);
            chk("last_gap", last_gap, m_gap);
            chk("gap_valid", gap_valid, m_gv);
            chk("locked", locked, m_locked);
            chk("err_gap", err_gap, m_eg);
            chk("err_width", err_width, m_ew);
            chk("hist", hist, m_hist);
        end
    end

    task automatic cyc(input logic y);
        y_in = y;
        @(posedge clk);
        #1;
    endtask

    task automatic train(input int period, input int n, input int width);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < period; k++) cyc(k < width);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_cnt"}, pulse_count, 0);
        chk({name, "_gap"}, last_gap, 0);
        chk({name, "_gv"}, gap_valid, 0);
        chk({name, "_lock"}, locked, 0);
        chk({name, "_eg"}, err_gap, 0);
        chk({name, "_ew"}, err_width, 0);
        chk({name, "_hist"}, hist, 0);
    endtask

    initial begin
        int cnt_before;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        cmp_en = 1'b1;
        cyc(0);

        // Steady period 5: lock on the 5th rise.
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (i == 1) chk("t1_first_gv", gap_valid, 1);
            if (i == 3) chk("t1_not_yet_locked", locked, 0);
            if (i < 4) repeat (4) cyc(0);
        end
        chk("t1_locked", locked, 1);
        chk("t1_cnt", pulse_count, 5);
        chk("t1_gap", last_gap, 5);
        repeat (4) cyc(0);

        // One gap of 6 while locked, then relock after four gaps of 5.
        cyc(0);
        cyc(1);
        chk("t2_gap6", last_gap, 6);
        chk("t2_err_gap", err_gap, 1);
        chk("t2_unlocked", locked, 0);
        repeat (4) cyc(0);
        train(5, 4, 1);
        chk("t2_relocked", locked, 1);
        chk("t2_err_sticky", err_gap, 1);

        // Three-cycle wide pulse: one count, width error.
        cnt_before = pulse_count;
        train(5, 1, 3);
        chk("t3_cnt", pulse_count, cnt_before + 1);
        chk("t3_err_width", err_width, 1);

        // Clear on the same edge as a rise.
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk_zero("t4");
        cyc(0);
        chk("t4_no_count", pulse_count, 0);

        // Long idle: gap saturates.
        cyc(1);
        repeat (300) cyc(0);
        cyc(1);
        chk("t5_sat_gap", last_gap, 255);
        chk("t5_gv", gap_valid, 1);
        repeat (4) cyc(0);

        // Lock, then an asynchronous reset between edges.
        train(5, 5, 1);
        chk("t6_locked", locked, 1);
        #2 reset = 1'b1;
        #1 chk_zero("t6_async");
        reset = 1'b0;
        cyc(1);
        cyc(0);
        cyc(0);
`ifdef SEQ_MON_HIST_EN
        chk("t6_hist", hist, 8'b0000_0100);
`else
        chk("t6_hist", hist, 0);
`endif
        chk("t6_cnt", pulse_count, 1);

        // Randomized segments of periodic pulses with occasional wrong expectations and clears.
        for (int s = 0; s < 80; s++) begin
            int p, n, w;
            p = $urandom_range(3, 9);
            n = $urandom_range(2, 8);
            w = ($urandom_range(0, 5) == 0) ? 2 : 1;
            expected_gap = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'(p);
            if ($urandom_range(0, 15) == 0) begin
                clear = 1'b1;
                cyc(1'($urandom_range(0, 1)));
                clear = 1'b0;
            end
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < p; k++) begin
                    if ($urandom_range(0, 40) == 0) cyc(1'($urandom_range(0, 1)));
                    else cyc(k < w);
                end
            end
        end

        cyc(0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
